risc16_mem_responder: RTL

- Memory-side responder for the risc16ba core. It serves the core's instruction-fetch port (iaddr/ioe/idin) and data port (daddr/ddout/doe/dwe0/dwe1/ddin) from one unified memory with two read ports and one write port.
- It contains a byte-stream boot loader that fills memory while holding the core in reset, then releases it.
- It counts run cycles for performance measurement.
- It sits between the core and the top level. The host or testbench drives the loader stream.

---
 rtl/risc16_mem_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/risc16_mem_responder.sv
// Unified memory responder for the risc16ba core: two combinational read ports,
// one byte-lane write port, a byte-stream boot loader and a saturating run-cycle counter.
module risc16_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter bit BOOT_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       iaddr,
  input  logic              ioe,
  output logic [15:0]       idin,
  input  logic [15:0]       daddr,
  input  logic              doe,
  input  logic              dwe0,
  input  logic              dwe1,
  input  logic [15:0]       ddout,
  output logic [15:0]       ddin,
  output logic              cpu_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic [ADDR_W:0]   load_words,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              phase_q, phase_d;
  logic [7:0]        hold_q, hold_d;
  logic [ADDR_W:0]   load_words_q, load_words_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              wr_hi, wr_lo;
  logic [ADDR_W-1:0] wr_idx;
  logic [15:0]       wr_data;
  logic              ld_accept;

  logic [15:0] mem [DEPTH];

  logic [ADDR_W-1:0] i_idx, d_idx;
  assign i_idx = iaddr[ADDR_W:1];
  assign d_idx = daddr[ADDR_W:1];

  // Byte 0 and high address bits alias; ddin is valid only while doe is high.
  logic unused_inputs;
  assign unused_inputs = ^{iaddr[0], daddr[0], iaddr >> (ADDR_W + 1),
                           daddr >> (ADDR_W + 1), doe};

  // Reads are asynchronous, so a same-cycle write is seen only after the edge.
  assign idin = ioe ? mem[i_idx] : 16'h0000;
  assign ddin = mem[d_idx];

  // Loader handshake: a byte transfers on any edge where ld_valid && ld_ready;
  // ld_ready is high exactly while in LOAD and ld_data/ld_last are ignored otherwise.
  assign ld_ready  = (state_q == ST_LOAD);
  assign ld_accept = ld_ready && ld_valid;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    load_words_d = load_words_q;
    run_cycles_d = run_cycles_q;
    cpu_rst_d    = cpu_rst_q;
    wr_hi        = 1'b0;
    wr_lo        = 1'b0;
    wr_idx       = ptr_q;
    wr_data      = 16'h0000;

    case (state_q)
      ST_LOAD: begin
        cpu_rst_d = 1'b1;
        if (ld_accept) begin
          if (!phase_q && !ld_last) begin
            hold_d  = ld_data;
            phase_d = 1'b1;
          end else begin
            // A lone final byte lands in the high lane, low lane zero-filled.
            wr_hi   = 1'b1;
            wr_lo   = 1'b1;
            wr_idx  = ptr_q;
            wr_data = phase_q ? {hold_q, ld_data} : {ld_data, 8'h00};
            ptr_d   = ptr_q + ADDR_W'(1);
            phase_d = 1'b0;
            if (load_words_q != WORDS_MAX) begin
              load_words_d = load_words_q + (ADDR_W + 1)'(1);
            end
            if (ld_last) begin
              state_d   = ST_RUN;
              cpu_rst_d = 1'b0;
            end
          end
        end
      end
      default: begin
        cpu_rst_d = 1'b0;
        if (run_cycles_q != CNT_MAX) begin
          run_cycles_d = run_cycles_q + CNT_W'(1);
        end
        wr_hi   = dwe0;
        wr_lo   = dwe1;
        wr_idx  = d_idx;
        wr_data = ddout;
      end
    endcase

    if (rst) begin
      state_d      = BOOT_EN ? ST_LOAD : ST_RUN;
      ptr_d        = '0;
      phase_d      = 1'b0;
      hold_d       = 8'h00;
      load_words_d = '0;
      run_cycles_d = '0;
      cpu_rst_d    = 1'b1;
      wr_hi        = 1'b0;
      wr_lo        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    ptr_q        <= ptr_d;
    phase_q      <= phase_d;
    hold_q       <= hold_d;
    load_words_q <= load_words_d;
    run_cycles_q <= run_cycles_d;
    cpu_rst_q    <= cpu_rst_d;
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_hi) mem[wr_idx][15:8] <= wr_data[15:8];
    if (wr_lo) mem[wr_idx][7:0]  <= wr_data[7:0];
  end

  assign cpu_rst    = cpu_rst_q;
  assign load_words = load_words_q;
  assign run_cycles = run_cycles_q;

endmodule
